// File: rtl/multitap_keypad_ctrl.sv
// Matrix keypad scanner with debounce and multi-tap letter entry.
// Committed ASCII letters leave through a one-entry valid/ready register.
module multitap_keypad_ctrl #(
    parameter int NUM_ROWS        = 4,
    parameter int NUM_COLS        = 3,
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int TAP_TIMEOUT     = 100,
    parameter int LETTERS_PER_KEY = 3,
    parameter int NUM_LETTER_KEYS = 9,
    parameter int SUBMIT_KEY      = 9,
    parameter int CLEAR_KEY       = 10,
    parameter int WORD_KEY        = 11
) (
    input  logic                clk,
    input  logic                nRst,
    input  logic                enable,
    input  logic [NUM_ROWS-1:0] row_in,
    output logic [NUM_COLS-1:0] col_drive,
    output logic [7:0]          pend_letter,
    output logic                pend_valid,
    output logic [7:0]          out_letter,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                word_submit,
    output logic                key_error
);

    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;
    localparam int KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam int TW = $clog2(TAP_TIMEOUT + 1);
    localparam int IW = $clog2(LETTERS_PER_KEY + 1);

    localparam logic [1:0] K_NONE   = 2'd0;
    localparam logic [1:0] K_SINGLE = 2'd1;
    localparam logic [1:0] K_MULTI  = 2'd2;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_TAP  = 1'b1;

    function automatic logic [7:0] letter_of(input logic [KW-1:0] key, input logic [IW-1:0] idx);
        letter_of = 8'h41 + 8'(key) * 8'(LETTERS_PER_KEY) + 8'(idx);
    endfunction

    // Next tap index: wraps after the last letter of the key or past 'Z'.
    function automatic logic [IW-1:0] next_idx(input logic [KW-1:0] key, input logic [IW-1:0] idx);
        logic [IW-1:0] n;
        n = idx + IW'(1);
        if ((n >= IW'(LETTERS_PER_KEY)) || (letter_of(key, n) > 8'h5A)) begin
            next_idx = '0;
        end else begin
            next_idx = n;
        end
    endfunction

    logic [CW-1:0] col_q, col_d;
    logic [1:0]    acc_cnt_q, acc_cnt_d;
    logic [KW-1:0] acc_key_q, acc_key_d;
    logic [1:0]    prev_kind_q, prev_kind_d;
    logic [KW-1:0] prev_key_q, prev_key_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          pressed_q, pressed_d;
    logic          press_vld_q, press_vld_d;
    logic [KW-1:0] press_key_q, press_key_d;

    logic [0:0]    state_q, state_d;
    logic [KW-1:0] tap_key_q, tap_key_d;
    logic [IW-1:0] tap_idx_q, tap_idx_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    pend_letter_q, pend_letter_d;
    logic [7:0]    out_letter_q, out_letter_d;
    logic          out_valid_q, out_valid_d;
    logic          word_submit_q, word_submit_d;
    logic          key_error_q, key_error_d;

    logic [1:0]    row_cnt_s, base_cnt_s, frame_cnt_s, kind_s;
    logic [2:0]    sum_s;
    logic [KW-1:0] row_key_s, frame_key_s;
    logic          frame_end_s, same_s, press_s, release_s, multi_err_s;
    logic [DW-1:0] cnt_next_s;
    logic          can_load_s, commit_s, is_letter_s;

    assign col_drive   = enable ? (NUM_COLS'(1) << col_q) : '0;
    assign pend_letter = pend_letter_q;
    assign pend_valid  = (state_q == S_TAP);
    assign out_letter  = out_letter_q;
    assign out_valid   = out_valid_q;
    assign word_submit = word_submit_q;
    assign key_error   = key_error_q;

    // Classify the frame: rows hit in this column merged with earlier columns.
    always_comb begin
        row_cnt_s = 2'd0;
        row_key_s = '0;
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            row_cnt_s = (row_cnt_s == 2'd2) ? 2'd2 : row_cnt_s + {1'b0, row_in[r]};
            row_key_s = row_in[r] ? (KW'(r * NUM_COLS) + KW'(col_q)) : row_key_s;
        end
        base_cnt_s  = (col_q == '0) ? 2'd0 : acc_cnt_q;
        sum_s       = {1'b0, base_cnt_s} + {1'b0, row_cnt_s};
        frame_cnt_s = (sum_s >= 3'd2) ? 2'd2 : sum_s[1:0];
        frame_key_s = (base_cnt_s == 2'd0) ? row_key_s : acc_key_q;
        frame_end_s = enable && (col_q == CW'(NUM_COLS - 1));
        case (frame_cnt_s)
            2'd0:    kind_s = K_NONE;
            2'd1:    kind_s = K_SINGLE;
            default: kind_s = K_MULTI;
        endcase
        same_s = (kind_s == prev_kind_q) && ((kind_s != K_SINGLE) || (frame_key_s == prev_key_q));
        if (kind_s == K_MULTI) begin
            cnt_next_s = '0;
        end else if (same_s) begin
            cnt_next_s = (cnt_q == DW'(DEBOUNCE_FRAMES)) ? cnt_q : cnt_q + DW'(1);
        end else begin
            cnt_next_s = DW'(1);
        end
        press_s     = frame_end_s && (kind_s == K_SINGLE) && !pressed_q && (cnt_next_s == DW'(DEBOUNCE_FRAMES));
        release_s   = frame_end_s && (kind_s == K_NONE) && pressed_q && (cnt_next_s == DW'(DEBOUNCE_FRAMES));
        multi_err_s = frame_end_s && (kind_s == K_MULTI) && (prev_kind_q != K_MULTI);
    end

    // Scan counter, frame accumulator and debounce next state.
    always_comb begin
        col_d       = col_q;
        acc_cnt_d   = acc_cnt_q;
        acc_key_d   = acc_key_q;
        prev_kind_d = prev_kind_q;
        prev_key_d  = prev_key_q;
        cnt_d       = cnt_q;
        pressed_d   = pressed_q;
        press_vld_d = 1'b0;
        press_key_d = press_key_q;
        if (!enable) begin
            col_d       = '0;
            acc_cnt_d   = 2'd0;
            acc_key_d   = '0;
            prev_kind_d = K_NONE;
            prev_key_d  = '0;
            cnt_d       = '0;
            pressed_d   = 1'b0;
        end else begin
            col_d     = (col_q == CW'(NUM_COLS - 1)) ? '0 : col_q + CW'(1);
            acc_cnt_d = frame_cnt_s;
            acc_key_d = frame_key_s;
            if (frame_end_s) begin
                prev_kind_d = kind_s;
                prev_key_d  = frame_key_s;
                cnt_d       = cnt_next_s;
                pressed_d   = press_s ? 1'b1 : (release_s ? 1'b0 : pressed_q);
                press_vld_d = press_s;
                press_key_d = frame_key_s;
            end else begin
                press_key_d = press_key_q;
            end
        end
    end

    // Tap FSM, commit path and output handshake.
    always_comb begin
        state_d       = state_q;
        tap_key_d     = tap_key_q;
        tap_idx_d     = tap_idx_q;
        timer_d       = timer_q;
        commit_s      = 1'b0;
        word_submit_d = 1'b0;
        key_error_d   = multi_err_s;
        out_letter_d  = out_letter_q;
        out_valid_d   = out_valid_q && !out_ready;
        can_load_s    = !out_valid_q || out_ready;
        is_letter_s   = (int'(press_key_q) < NUM_LETTER_KEYS);
        if (!enable) begin
            state_d   = S_IDLE;
            tap_key_d = '0;
            tap_idx_d = '0;
            timer_d   = '0;
        end else if (state_q == S_IDLE) begin
            if (press_vld_q && is_letter_s) begin
                state_d   = S_TAP;
                tap_key_d = press_key_q;
                tap_idx_d = '0;
                timer_d   = '0;
            end else if (press_vld_q && (press_key_q == KW'(WORD_KEY))) begin
                word_submit_d = 1'b1;
            end else begin
                state_d = S_IDLE;
            end
        end else begin
            if (press_vld_q && is_letter_s && (press_key_q == tap_key_q)) begin
                tap_idx_d = next_idx(tap_key_q, tap_idx_q);
                timer_d   = '0;
            end else if (press_vld_q && (is_letter_s || (press_key_q == KW'(SUBMIT_KEY))
                                         || (press_key_q == KW'(WORD_KEY)))) begin
                // A blocked output drops the whole press, word pulse included.
                if (can_load_s) begin
                    commit_s      = 1'b1;
                    word_submit_d = (press_key_q == KW'(WORD_KEY));
                    if (is_letter_s) begin
                        tap_key_d = press_key_q;
                        tap_idx_d = '0;
                        timer_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    key_error_d = 1'b1;
                end
            end else if (press_vld_q && (press_key_q == KW'(CLEAR_KEY))) begin
                state_d = S_IDLE;
            end else if (timer_q >= TW'(TAP_TIMEOUT - 1)) begin
                if (can_load_s) begin
                    commit_s = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    timer_d = timer_q;
                end
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end
        if (state_d == S_IDLE) begin
            tap_key_d     = '0;
            tap_idx_d     = '0;
            timer_d       = '0;
            pend_letter_d = 8'h00;
        end else begin
            pend_letter_d = letter_of(tap_key_d, tap_idx_d);
        end
        if (commit_s) begin
            out_letter_d = pend_letter_q;
            out_valid_d  = 1'b1;
        end else begin
            out_letter_d = out_letter_q;
        end
    end

    // Scan and debounce registers.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            col_q       <= '0;
            acc_cnt_q   <= 2'd0;
            acc_key_q   <= '0;
            prev_kind_q <= K_NONE;
            prev_key_q  <= '0;
            cnt_q       <= '0;
            pressed_q   <= 1'b0;
            press_vld_q <= 1'b0;
            press_key_q <= '0;
        end else begin
            col_q       <= col_d;
            acc_cnt_q   <= acc_cnt_d;
            acc_key_q   <= acc_key_d;
            prev_kind_q <= prev_kind_d;
            prev_key_q  <= prev_key_d;
            cnt_q       <= cnt_d;
            pressed_q   <= pressed_d;
            press_vld_q <= press_vld_d;
            press_key_q <= press_key_d;
        end
    end

    // FSM and output registers.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q       <= S_IDLE;
            tap_key_q     <= '0;
            tap_idx_q     <= '0;
            timer_q       <= '0;
            pend_letter_q <= 8'h00;
            out_letter_q  <= 8'h00;
            out_valid_q   <= 1'b0;
            word_submit_q <= 1'b0;
            key_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            tap_key_q     <= tap_key_d;
            tap_idx_q     <= tap_idx_d;
            timer_q       <= timer_d;
            pend_letter_q <= pend_letter_d;
            out_letter_q  <= out_letter_d;
            out_valid_q   <= out_valid_d;
            word_submit_q <= word_submit_d;
            key_error_q   <= key_error_d;
        end
    end

endmodule

// File: doc/multitap_keypad_ctrl.md
Name: multitap_keypad_ctrl

Overview:
Parametrised keypad front-end for the hangman host and player consoles. It scans an R×C matrix keypad, debounces it, and converts multi-tap letter entry into committed ASCII letters, with automatic commit after a tap timeout. Special keys cover submit, clear and word-submit. Committed letters leave through a one-entry valid/ready output register to the game/message logic.

Parameters:
NUM_ROWS, 4, keypad rows (row_in width)
NUM_COLS, 3, keypad columns (col_drive width)
DEBOUNCE_FRAMES, 3, consecutive identical scan frames required for press/release
TAP_TIMEOUT, 100, idle cycles in TAPPING before auto-commit (1 s at 100 Hz)
LETTERS_PER_KEY, 3, letters cycled per letter key
NUM_LETTER_KEYS, 9, key_ids 0..NUM_LETTER_KEYS-1 are letter keys
SUBMIT_KEY, 9, key_id that commits the pending letter
CLEAR_KEY, 10, key_id that discards the pending letter
WORD_KEY, 11, key_id that commits any pending letter and signals end of word

Ports:
clk  in  1  system clock
nRst  in  1  asynchronous active-low reset
enable  in  1  block active; low = scanning stopped, tap state cleared
row_in  in  NUM_ROWS  active-high row sense for the currently driven column
col_drive  out  NUM_COLS  one-hot active-high column drive
pend_letter  out  8  ASCII letter currently being tapped
pend_valid  out  1  high in TAPPING
out_letter  out  8  committed ASCII letter
out_valid  out  1  out_letter valid; held until accepted
out_ready  in  1  consumer accepts when out_valid && out_ready
word_submit  out  1  one-cycle pulse on WORD_KEY press event
key_error  out  1  one-cycle pulse on rejected input

Behaviour:
- Reset (async, nRst=0): col index 0, debounce counters 0, key released, state IDLE, pend_letter=0, pend_valid=0, out_letter=0, out_valid=0, word_submit=0, key_error=0.
- Scan: col index advances 0..NUM_COLS-1 each cycle with wrap. col_drive = enable ? onehot(col index) : 0. row_in is sampled in the same cycle. key_id = row*NUM_COLS + col.
- Frame: NUM_COLS cycles. At the last cycle, the frame is classified as NONE, SINGLE(key_id) or MULTI.
- Debounce: press event fires when SINGLE(k) has been seen in DEBOUNCE_FRAMES consecutive frames while released; the event is registered the cycle after the closing frame. Release occurs after DEBOUNCE_FRAMES consecutive NONE frames. No auto-repeat.
- MULTI frame: restarts the stable count. key_error pulses on the first MULTI frame following a non-MULTI frame.
- Letter mapping: base(k) = 8'h41 + k*LETTERS_PER_KEY. letter = base + tap_idx. If letter > 'Z', tap_idx wraps to 0.
- FSM states IDLE, TAPPING. Letter key k press event:
  - IDLE: tap_key=k, tap_idx=0, timer=0, go to TAPPING.
  - TAPPING, same key: tap_idx advances mod LETTERS_PER_KEY, with the 'Z' wrap above; timer=0.
  - TAPPING, different key: commit the pending letter, then start k as from IDLE.
- SUBMIT_KEY: TAPPING → commit and go to IDLE. In IDLE it is a no-op.
- CLEAR_KEY: TAPPING → IDLE with no commit. In IDLE it is a no-op.
- WORD_KEY: word_submit pulses. In TAPPING it also commits, in the same cycle.
- Other key_ids (≥ NUM_LETTER_KEYS, not special) are ignored.
- Timeout: in TAPPING, timer increments each cycle with no press event. At TAP_TIMEOUT, auto-commit and go to IDLE.
- Commit: out_letter<=pend_letter, out_valid<=1 on the next edge. out_valid clears on out_valid&&out_ready. Acceptance and a new commit in the same cycle: new letter loaded, out_valid stays 1.
- Blocked commit (out_valid=1 && !out_ready):
  - Key-triggered commit: key_error pulses, the press event is dropped, pending is unchanged.
  - Timeout commit: waits in TAPPING until the output frees.
- enable=0: state IDLE, pending cleared, debounce cleared. Output register and handshake are retained.
- Reset mid-operation clears everything, including an unaccepted out_letter.

Test Plan:
- Reset with nRst=0, then enable=1 → all outputs 0; col_drive cycles 001,010,100,001.
- Key 0 (row0,col0) tapped once, then SUBMIT → out_letter=8'h41 'A'. Tapped 3× → 'C'. Tapped 4× → 'A'.
- Key 8 tapped 1/2/3× → 'Y'/'Z'/'Y' (wrap past 'Z').
- Key 1 tapped 2×, then idle → pend_letter='E'; out_valid rises with 'E' exactly TAP_TIMEOUT+1 cycles after the second press event.
- out_ready=0: commit 'A', press key 1 (pend 'D'), press key 2 → key_error, pend stays 'D'. Raise out_ready → 'A' accepted, out_valid=0.
- Keys 0 and 1 held together → one key_error, no press. TAPPING 'B' then WORD_KEY → out_letter 'B' plus word_submit pulse. nRst low mid-tap → pend_valid=0, out_valid=0.
